// File: rtl/frame_capture_ctrl.sv
// Captures one camera frame into the frame buffer. Writes are registered one cycle after each pixel strobe.
// There is no backpressure: the RAM port accepts every write. CAPTURE_ROI_EN enables the capture window offset.
module frame_capture_ctrl #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17,
  parameter int PIX_W    = 8,
  parameter int ROI_X0   = 0,
  parameter int ROI_Y0   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_pix_valid,
  input  logic [PIX_W-1:0]  cam_data,
  output logic              busy,
  output logic              done,
  output logic              short_frame,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

`ifdef CAPTURE_ROI_EN
  localparam int X0 = ROI_X0;
  localparam int Y0 = ROI_Y0;
`else
  // Window pinned to the frame origin; the offset parameters have no effect.
  localparam int X0 = 0 * ROI_X0;
  localparam int Y0 = 0 * ROI_Y0;
`endif

  localparam int COL_W  = $clog2(X0 + H_PIXELS + 1);
  localparam int LINE_W = $clog2(Y0 + V_LINES + 1);
  localparam logic [COL_W-1:0]  COL_END  = COL_W'(X0 + H_PIXELS);
  localparam logic [LINE_W-1:0] LINE_END = LINE_W'(Y0 + V_LINES);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  dat;
  } wr_t;

  state_t              state_q, state_d;
  logic                vsync_q, href_q;
  logic [COL_W-1:0]    col_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   line_inc;
  logic [ADDR_W-1:0]   addr_q;
  logic                short_q;
  wr_t                 wr_q;

  logic vsync_fe, vsync_re, href_fe;
  logic in_window, frame_complete;
  logic clr_cnt, store, col_adv, line_adv, set_short;

  assign vsync_fe = ~cam_vsync & vsync_q;
  assign vsync_re = cam_vsync & ~vsync_q;
  assign href_fe  = ~cam_href & href_q;
  assign line_inc = line_q + 1'b1;

  // The line closed by href_fe finishes the window when it is the last stored line.
  assign frame_complete = href_fe && (line_inc == LINE_END);

`ifdef CAPTURE_ROI_EN
  localparam logic [COL_W-1:0]  COL_START  = COL_W'(X0);
  localparam logic [LINE_W-1:0] LINE_START = LINE_W'(Y0);
  assign in_window = (col_q >= COL_START) && (col_q < COL_END) && (line_q >= LINE_START);
`else
  assign in_window = (col_q < COL_END);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    clr_cnt   = 1'b0;
    store     = 1'b0;
    col_adv   = 1'b0;
    line_adv  = 1'b0;
    set_short = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr_cnt = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        busy = 1'b1;
        if (vsync_fe) state_d = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (cam_href && cam_pix_valid) begin
          col_adv = (col_q < COL_END);
          store   = in_window;
        end
        if (href_fe) begin
          line_adv = 1'b1;
          if (frame_complete) state_d = DONE;
        end
        // A line completing the window on the same cycle wins over the vsync rise.
        if (vsync_re && !frame_complete) begin
          set_short = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      col_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      short_q <= 1'b0;
      wr_q    <= '0;
    end else begin
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
      if (clr_cnt) begin
        col_q   <= '0;
        line_q  <= '0;
        addr_q  <= '0;
        short_q <= 1'b0;
      end else begin
        if (line_adv) begin
          col_q  <= '0;
          line_q <= line_inc;
        end else if (col_adv) begin
          col_q <= col_q + 1'b1;
        end
        if (set_short) short_q <= 1'b1;
        if (store) addr_q <= addr_q + 1'b1;
      end
      wr_q.en <= store;
      if (store) begin
        wr_q.addr <= addr_q;
        wr_q.dat  <= cam_data;
      end
    end
  end

  assign short_frame = short_q;
  assign wr_en       = wr_q.en;
  assign wr_addr     = wr_q.addr;
  assign wr_data     = wr_q.dat;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl at H_PIXELS=4, V_LINES=3; ROI scenarios run when CAPTURE_ROI_EN is defined.
module tb_frame_capture_ctrl;

  localparam int H = 4;
  localparam int V = 3;
`ifdef CAPTURE_ROI_EN
  localparam int RX0 = 1;
  localparam int RY0 = 1;
`else
  localparam int RX0 = 0;
  localparam int RY0 = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, cam_vsync, cam_href, cam_pix_valid;
  logic [7:0]  cam_data;
  logic        busy, done, short_frame, wr_en;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;

  frame_capture_ctrl #(
    .H_PIXELS(H), .V_LINES(V), .ADDR_W(17), .PIX_W(8), .ROI_X0(RX0), .ROI_Y0(RY0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_pix_valid(cam_pix_valid), .cam_data(cam_data), .busy(busy), .done(done),
    .short_frame(short_frame), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] got_addr[$], got_data[$], got_cyc[$];
  logic [31:0] exp_addr[$], exp_data[$], exp_cyc[$];
  int m_addr;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  logic busy_at_done = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(32'(wr_addr));
      got_data.push_back(32'(wr_data));
      got_cyc.push_back(32'(cyc));
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pix(input int l, input int p, input logic [7:0] d);
    if (l >= RY0 && l < RY0 + V && p >= RX0 && p < RX0 + H) begin
      exp_addr.push_back(32'(m_addr));
      exp_data.push_back(32'(d));
      exp_cyc.push_back(32'(cyc));
      m_addr++;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
    m_addr = 0;
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    step(5);
    cam_vsync = 1'b0;
    step(3);
  endtask

  task automatic send_lines(input int nl, input int np);
    for (int l = 0; l < nl; l++) begin
      cam_href = 1'b1;
      for (int p = 0; p < np; p++) begin
        cam_pix_valid = 1'b1;
        cam_data = 8'(8'h10 + l * np + p);
        push_pix(l, p, cam_data);
        step();
      end
      cam_pix_valid = 1'b0;
      cam_href = 1'b0;
      step(3);
    end
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    int n;
    chk({tag, "_wr_count"}, 32'(got_addr.size()), 32'(n_exp));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_wr_addr"}, got_addr[i], exp_addr[i]);
      chk({tag, "_wr_data"}, got_data[i], exp_data[i]);
      chk({tag, "_wr_latency"}, got_cyc[i], exp_cyc[i] + 32'd1);
    end
  endtask

  task automatic check_end(input string tag, input int done_before, input logic exp_short);
    step(4);
    chk({tag, "_done_pulses"}, 32'(done_cnt - done_before), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, "_done_after_last_wr"}, 32'(done_cyc > last_wr_cyc), 32'd1);
    chk({tag, "_short_frame"}, 32'(short_frame), 32'(exp_short));
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    logic [5:0] seen;
    reset = 1'b1; start = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
    cam_pix_valid = 1'b0; cam_data = 8'h00;
    step(3);
    reset = 1'b0;

    // Reset and idle: every output stays low.
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      seen |= {busy, done, short_frame, wr_en, |wr_addr, |wr_data};
      step();
    end
    chk("reset_outputs", 32'(seen), 32'd0);
    chk("reset_no_writes", 32'(got_addr.size()), 32'd0);

`ifndef CAPTURE_ROI_EN
    // Full frame: 3 lines x 4 pixels, data 0x10..0x1B.
    d0 = done_cnt;
    start_pulse();
    chk("t1_busy_rise", 32'(busy), 32'd1);
    vsync_pulse();
    chk("t1_busy_capture", 32'(busy), 32'd1);
    send_lines(3, 4);
    check_writes("t1", 12);
    chk("t1_first_data", got_data[0], 32'h10);
    chk("t1_last_addr", got_addr[11], 32'd11);
    chk("t1_last_data", got_data[11], 32'h1B);
    check_end("t1", d0, 1'b0);

    // Overlong lines: pixels 5 and 6 of each line are dropped.
    d0 = done_cnt;
    start_pulse();
    vsync_pulse();
    send_lines(3, 6);
    check_writes("t2", 12);
    chk("t2_line0_last", got_data[3], 32'h13);
    chk("t2_line1_first", got_data[4], 32'h16);
    chk("t2_last_addr", got_addr[11], 32'd11);
    check_end("t2", d0, 1'b0);

    // Short frame: vsync rises after 2 lines.
    d0 = done_cnt;
    start_pulse();
    vsync_pulse();
    send_lines(2, 4);
    cam_vsync = 1'b1;
    step(2);
    check_writes("t3", 8);
    check_end("t3", d0, 1'b1);
    cam_vsync = 1'b0;
    step(2);
    start_pulse();
    chk("t3_short_cleared", 32'(short_frame), 32'd0);
    chk("t3_rearmed_busy", 32'(busy), 32'd1);

    // Extra start during capture is ignored; reset in line 2 aborts with no done.
    vsync_pulse();
    d0 = done_cnt;
    cam_href = 1'b1;
    for (int p = 0; p < 4; p++) begin
      start = (p == 1);
      cam_pix_valid = 1'b1;
      cam_data = 8'(8'h40 + p);
      push_pix(0, p, cam_data);
      step();
    end
    start = 1'b0; cam_pix_valid = 1'b0; cam_href = 1'b0;
    step(3);
    chk("t4_busy_after_extra_start", 32'(busy), 32'd1);
    cam_href = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cam_pix_valid = 1'b1;
      cam_data = 8'(8'h50 + p);
      push_pix(1, p, cam_data);
      step();
    end
    reset = 1'b1;
    cam_data = 8'h52;
    step();
    reset = 1'b0;
    chk("t4_reset_busy", 32'(busy), 32'd0);
    chk("t4_reset_wr_en", 32'(wr_en), 32'd0);
    chk("t4_reset_done", 32'(done), 32'd0);
    cam_data = 8'h53;
    step();
    cam_pix_valid = 1'b0; cam_href = 1'b0;
    step(2);
    cam_href = 1'b1; cam_pix_valid = 1'b1;
    step(4);
    cam_href = 1'b0; cam_pix_valid = 1'b0;
    cam_vsync = 1'b1;
    step(3);
    cam_vsync = 1'b0;
    step(4);
    check_writes("t4", 6);
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_short", 32'(short_frame), 32'd0);
`else
    // Window offset (1,1): 4 lines x 5 pixels, first stored pixel is line 1 col 1.
    d0 = done_cnt;
    start_pulse();
    chk("roi_busy_rise", 32'(busy), 32'd1);
    vsync_pulse();
    send_lines(4, 5);
    check_writes("roi", 12);
    chk("roi_first_data", got_data[0], 32'h16);
    chk("roi_last_addr", got_addr[11], 32'd11);
    chk("roi_last_data", got_data[11], 32'h23);
    check_end("roi", d0, 1'b0);

    // Window incomplete when vsync rises.
    d0 = done_cnt;
    start_pulse();
    vsync_pulse();
    send_lines(3, 5);
    cam_vsync = 1'b1;
    step(2);
    check_writes("roi_short", 8);
    check_end("roi_short", d0, 1'b1);
    cam_vsync = 1'b0;
    step(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Sequences capture of one camera frame into the frame buffer. Watches synchronized camera VSYNC/HREF for edges, arms on a software start pulse, waits for the next frame start, then emits write strobes, linear addresses and pixel data for up to H_PIXELS x V_LINES pixels. Sits between the camera input synchronizers and the frame-buffer RAM write port; status feeds the vision pipeline's frame scheduler.

## Interface
- H_PIXELS, 320, pixels stored per line
- V_LINES, 240, lines stored per frame
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES
- PIX_W, 8, pixel data width
- ROI_X0, 0, first stored column (used only with CAPTURE_ROI_EN)
- ROI_Y0, 0, first stored line (used only with CAPTURE_ROI_EN)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  capture request; sampled only in IDLE
- cam_vsync  in  1  frame sync, already synchronized to clk; high during vertical blanking
- cam_href  in  1  line valid, already synchronized to clk
- cam_pix_valid  in  1  one-cycle strobe per pixel, meaningful only while cam_href=1
- cam_data  in  PIX_W  pixel value, valid with cam_pix_valid
- busy  out  1  high in ARM and CAPTURE
- done  out  1  one-cycle pulse when a capture finishes
- short_frame  out  1  sticky; set if vsync rose before V_LINES lines were stored; cleared on next accepted start
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  frame-buffer write address
- wr_data  out  PIX_W  frame-buffer write data

## Operation
- Edge detection: registers vsync_q, href_q each cycle. vsync_fe = !cam_vsync & vsync_q; vsync_re = cam_vsync & !vsync_q; href_fe = !cam_href & href_q. On reset, vsync_q and href_q are cleared.
- States: IDLE, ARM, CAPTURE, DONE.
- IDLE: start=1 -> ARM; clears short_frame, col, line and address counters.
- ARM: waits for vsync_fe -> CAPTURE. A frame already in progress when armed is never partially captured.
- CAPTURE: on each cycle with cam_href=1 and cam_pix_valid=1, a pixel is stored if col < H_PIXELS. The pixel is then written at wr_addr = running address counter, and the counter increments. col increments on every valid pixel and saturates at H_PIXELS. Extra pixels on the line are dropped.
- href_fe in CAPTURE: col <- 0 and line <- line+1. If line+1 == V_LINES -> DONE.
- vsync_re in CAPTURE before V_LINES lines are stored: set short_frame -> DONE.
- Simultaneous href_fe and vsync_re: line increments first. If that completes V_LINES, short_frame stays 0.
- DONE: done=1 for exactly one cycle -> IDLE.
- start in ARM, CAPTURE or DONE is ignored; it does not queue.
- Address arithmetic: wr_addr is the running counter, never multiplied. Its maximum is H_PIXELS*V_LINES-1, and it never wraps.
- Reset mid-operation: the block returns to IDLE the next cycle. Any in-flight write is discarded (wr_en=0) and no done pulse is issued.

## Timing
- Reset values: busy=0, done=0, short_frame=0, wr_en=0, wr_addr=0, wr_data=0; state=IDLE.
- busy rises the cycle after start is sampled in IDLE.
- Edge detect adds one cycle: CAPTURE is entered the cycle after the first cycle with cam_vsync=0 following a high.
- Write latency: wr_en, wr_addr and wr_data are registered and asserted 1 cycle after the qualifying cam_pix_valid. wr_en is high for 1 cycle per stored pixel.
- The last write of the frame and the done pulse: done is asserted no earlier than the cycle after the final wr_en.
- Back-to-back pixels (cam_pix_valid every cycle) are supported at full rate.

## Configuration
- CAPTURE_ROI_EN defined:
  - Pixels with column index < ROI_X0 are skipped; the column index counts valid pixels from 0.
  - Lines with index < ROI_Y0 are skipped. They still advance the raw line count but not the stored count.
  - Storage starts at address 0 with the first in-window pixel.
  - Window size remains H_PIXELS x V_LINES.
  - short_frame also sets if vsync rises before the window completes.
- CAPTURE_ROI_EN undefined: ROI_X0 and ROI_Y0 are ignored; the window starts at column 0, line 0.

## Test plan
All scenarios use H_PIXELS=4, V_LINES=3.
- Reset then idle 10 cycles -> all outputs 0, no wr_en.
- start pulse, then vsync high for 5 cycles then low, then 3 lines of 4 pixels with data 0x10..0x1B -> 12 writes at wr_addr 0..11 with matching data, each 1 cycle after its strobe. done pulses once, busy falls with it, short_frame=0.
- Same frame but 6 pixels per line -> pixels 5-6 of each line are dropped, still 12 writes at 0..11.
- Only 2 lines, then vsync rises -> 8 writes, done pulses, short_frame=1. A new start clears short_frame.
- start asserted while busy, plus reset asserted during line 2 -> the extra start is ignored. After reset: state IDLE, wr_en=0 from the next cycle, no done pulse.
- CAPTURE_ROI_EN with ROI_X0=1, ROI_Y0=1, and a 4-line, 5-pixel frame -> 12 writes. The first write is the pixel at line 1, column 1.
